// File: rtl/tuple_delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tuple_delay_pkg
//  Purpose : Shared defaults and the packed tuple layout for tuple_delay_3.
//            tuple_t places field1 in the upper bits and field2 in the lower
//            bits. This matches the word {input1, input2} carried by the
//            delay line.
//  Revision: 1.0 - initial release
// ============================================================================
package tuple_delay_pkg;

    localparam int c_W1    = 4;
    localparam int c_W2    = 4;
    localparam int c_DEPTH = 3;

    typedef struct packed {
        logic [c_W1-1:0] field1;
        logic [c_W2-1:0] field2;
    } tuple_t;

endpackage : tuple_delay_pkg
`default_nettype wire

// File: rtl/tuple_delay_3_delay_stage.sv
`default_nettype none
// ============================================================================
//  Module  : delay_stage
//  Purpose : One pipeline register. The clear is synchronous and active-high,
//            and it forces the register to zero.
//  Ports   : i_clk  - clock, rising edge
//            i_rst  - synchronous active-high clear
//            i_d    - data in  [WIDTH-1:0]
//            o_q    - registered data out [WIDTH-1:0]
//  Revision: 1.0 - initial release
// ============================================================================
module delay_stage #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : delay_stage
`default_nettype wire

// File: rtl/tuple_delay_3.sv
`default_nettype none
// ============================================================================
//  Module  : tuple_delay_3
//  Purpose : Packs {_i_input1, _i_input2} into a single word. It then delays
//            that word by DEPTH clock cycles. There is no handshake, so the
//            data advances on every rising edge.
//  Ports   : _i_clk          - clock, rising edge
//            _i_rst          - synchronous active-high reset; clears all stages
//            _i_input1       - first tuple field  [W1-1:0]  (upper bits)
//            _i_input2       - second tuple field [W2-1:0]  (lower bits)
//            _i_valid        - input qualifier (TUPLE_DELAY_VALID_EN only)
//            __output_valid  - delayed qualifier (TUPLE_DELAY_VALID_EN only)
//            __output        - delayed packed tuple [W1+W2-1:0]
//  Config  : define TUPLE_DELAY_VALID_EN to add a valid flag. The flag travels
//            alongside the data with the same latency.
//  Revision: 1.0 - initial release
// ============================================================================
module tuple_delay_3
    import tuple_delay_pkg::*;
#(
    parameter int W1    = c_W1,
    parameter int W2    = c_W2,
    parameter int DEPTH = c_DEPTH
) (
    input  logic             _i_clk,
    input  logic             _i_rst,
    input  logic [W1-1:0]    _i_input1,
    input  logic [W2-1:0]    _i_input2,
`ifdef TUPLE_DELAY_VALID_EN
    input  logic             _i_valid,
    output logic             __output_valid,
`endif
    output logic [W1+W2-1:0] __output
);

    localparam int c_WW = W1 + W2;

    logic [c_WW-1:0] w_packed;
    logic [c_WW-1:0] w_stage [DEPTH];

    assign w_packed = {_i_input1, _i_input2};

    // Build the data delay line. Stage 0 captures the packed word, and every
    // later stage captures the stage before it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_data_stage
        logic [c_WW-1:0] w_d;
        if (gi == 0) begin : g_first
            assign w_d = w_packed;
        end else begin : g_chain
            assign w_d = w_stage[gi-1];
        end

        delay_stage #(
            .WIDTH (c_WW)
        ) u_stage (
            .i_clk (_i_clk),
            .i_rst (_i_rst),
            .i_d   (w_d),
            .o_q   (w_stage[gi])
        );
    end

    // The last stage is a register, so no combinational path exists from the
    // inputs to the output.
    assign __output = w_stage[DEPTH-1];

`ifdef TUPLE_DELAY_VALID_EN
    logic w_vstage [DEPTH];

    // The valid chain is independent of the data chain. Data still shifts
    // every cycle, whatever the state of the valid flag.
    for (genvar gv = 0; gv < DEPTH; gv++) begin : g_valid_stage
        logic w_vd;
        if (gv == 0) begin : g_first
            assign w_vd = _i_valid;
        end else begin : g_chain
            assign w_vd = w_vstage[gv-1];
        end

        delay_stage #(
            .WIDTH (1)
        ) u_vstage (
            .i_clk (_i_clk),
            .i_rst (_i_rst),
            .i_d   (w_vd),
            .o_q   (w_vstage[gv])
        );
    end

    assign __output_valid = w_vstage[DEPTH-1];
`endif

endmodule : tuple_delay_3
`default_nettype wire

// File: tb/tb_tuple_delay_3.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tuple_delay_3
//  Purpose : Directed self-checking bench for tuple_delay_3 at its default
//            widths and depth (W1 = 4, W2 = 4, DEPTH = 3). Every expected
//            value is computed by hand from the 3-cycle latency.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_tuple_delay_3;
    import tuple_delay_pkg::*;

    logic       clk;
    logic       r_rst;
    logic [3:0] r_in1;
    logic [3:0] r_in2;
    logic       r_valid;
    logic [7:0] w_out;
`ifdef TUPLE_DELAY_VALID_EN
    logic       w_out_valid;
`endif

    int checks   = 0;
    int failures = 0;

    tuple_delay_3 dut (
        ._i_clk         (clk),
        ._i_rst         (r_rst),
        ._i_input1      (r_in1),
        ._i_input2      (r_in2),
`ifdef TUPLE_DELAY_VALID_EN
        ._i_valid       (r_valid),
        .__output_valid (w_out_valid),
`endif
        .__output       (w_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then return just after the rising edge that
    // samples them. At that point the DUT outputs reflect that edge.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b, input logic v);
        r_rst   = rst;
        r_in1   = a;
        r_in2   = b;
        r_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tuple_t t;
        logic [7:0] exp_s;

        r_rst   = 1'b1;
        r_in1   = 4'hF;
        r_in2   = 4'hF;
        r_valid = 1'b0;

        // Reset hold: the output is zero while reset is held, with nonzero inputs.
        step(1'b1, 4'hF, 4'hF, 1'b0); check("rst_hold0", {24'd0, w_out}, 32'h00);
        step(1'b1, 4'hA, 4'h5, 1'b0); check("rst_hold1", {24'd0, w_out}, 32'h00);
        // After release the output stays zero for two edges. The FF sampled on
        // the first edge after release then appears on the third.
        step(1'b0, 4'hF, 4'hF, 1'b0); check("post_rst0", {24'd0, w_out}, 32'h00);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("post_rst1", {24'd0, w_out}, 32'h00);
        // Single pulse 0/1 sampled on this edge.
        step(1'b0, 4'h0, 4'h1, 1'b0); check("first_ff",  {24'd0, w_out}, 32'hFF);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("pulse_pre", {24'd0, w_out}, 32'h00);
        // Field-order tuple A/5 sampled on this edge.
        step(1'b0, 4'hA, 4'h5, 1'b0); check("pulse_out", {24'd0, w_out}, 32'h01);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("pulse_end", {24'd0, w_out}, 32'h00);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("order_a5",  {24'd0, w_out}, 32'hA5);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("order_end", {24'd0, w_out}, 32'h00);

        // Streaming 00, 11 ... FF on consecutive cycles. Each value emerges
        // two edges after the edge that samples it, so the output sequence is
        // shifted by the latency with no gaps or duplicates.
        for (int k = 0; k < 16; k++) begin
            t.field1 = k[3:0];
            t.field2 = k[3:0];
            step(1'b0, t.field1, t.field2, 1'b0);
            exp_s = (k >= 2) ? {k[3:0] - 4'd2, k[3:0] - 4'd2} : 8'h00;
            check($sformatf("stream%0d", k), {24'd0, w_out}, {24'd0, exp_s});
        end

        // Mid-stream reset while DD, EE and FF are in flight. None of them may
        // appear at the output afterwards.
        step(1'b1, 4'h1, 4'h2, 1'b0); check("mid_rst",   {24'd0, w_out}, 32'h00);
        step(1'b0, 4'h3, 4'h4, 1'b0); check("mid_rst+1", {24'd0, w_out}, 32'h00);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("mid_rst+2", {24'd0, w_out}, 32'h00);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("mid_rst_34", {24'd0, w_out}, 32'h34);
        step(1'b0, 4'h0, 4'h0, 1'b0); check("mid_rst+4", {24'd0, w_out}, 32'h00);

        // Valid phase: valid is raised only alongside 3C. The reset cycle also
        // drives valid = 1, and the flag must still read 0.
        step(1'b1, 4'h3, 4'hC, 1'b1); check("v_rst_data", {24'd0, w_out}, 32'h00);
`ifdef TUPLE_DELAY_VALID_EN
        check("v_rst_flag", {31'd0, w_out_valid}, 32'd0);
`endif
        step(1'b0, 4'h3, 4'hC, 1'b1); check("v_c0_data", {24'd0, w_out}, 32'h00);
`ifdef TUPLE_DELAY_VALID_EN
        check("v_c0_flag", {31'd0, w_out_valid}, 32'd0);
`endif
        step(1'b0, 4'h0, 4'h0, 1'b0); check("v_c1_data", {24'd0, w_out}, 32'h00);
`ifdef TUPLE_DELAY_VALID_EN
        check("v_c1_flag", {31'd0, w_out_valid}, 32'd0);
`endif
        step(1'b0, 4'h0, 4'h0, 1'b0); check("v_c2_data", {24'd0, w_out}, 32'h3C);
`ifdef TUPLE_DELAY_VALID_EN
        check("v_c2_flag", {31'd0, w_out_valid}, 32'd1);
`endif
        step(1'b0, 4'h0, 4'h0, 1'b0); check("v_c3_data", {24'd0, w_out}, 32'h00);
`ifdef TUPLE_DELAY_VALID_EN
        check("v_c3_flag", {31'd0, w_out_valid}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tuple_delay_3
`default_nettype wire

// File: doc/tuple_delay_3.md
# tuple_delay_3

Fixed-latency pipeline that packs a two-field tuple into one word and delays it by three clock cycles. It serves as a retiming and alignment stage between pipelined datapath blocks whose tuple operands must arrive a fixed number of cycles later. No handshake: data advances on every clock edge.

## Interface
Parameters:
- W1, default 4: width of the first tuple field.
- W2, default 4: width of the second tuple field.
- DEPTH, default 3: register stages, i.e. latency in cycles; legal range is ≥ 1.

Ports:
- _i_clk  input  1  the single clock; all state updates on its rising edge.
- _i_rst  input  1  reset, synchronous and active-high; clears every stage.
- _i_input1  input  W1  first tuple field.
- _i_input2  input  W2  second tuple field.
- __output  output  W1+W2  delayed packed tuple.
- _i_valid  input  1  only with TUPLE_DELAY_VALID_EN; qualifies the input tuple.
- __output_valid  output  1  only with TUPLE_DELAY_VALID_EN; valid flag delayed with the data.

## Operation
- Packing: word = {_i_input1, _i_input2}. _i_input1 occupies bits [W1+W2-1:W2] and _i_input2 occupies bits [W2-1:0]. No arithmetic, no width change.
- Stage 0 <= packed word; stage k <= stage k-1 for k = 1..DEPTH-1.
- __output = stage DEPTH-1, driven directly from a register with no combinational path from the inputs.
- Reset: when _i_rst = 1 at a rising edge, all stages (and valid flags) load 0. This takes priority over the data shift.
- Reset asserted mid-operation discards all in-flight tuples, with no partial flush.
- X on the inputs propagates unchanged; no masking outside of reset.

## Timing
- Latency is exactly DEPTH rising edges; for the default, 3 cycles.
- A value sampled at edge n appears on __output after edge n+DEPTH-1 and holds until edge n+DEPTH.
- Throughput is one tuple per cycle; back-to-back distinct values must emerge back-to-back in order.
- Reset values: __output = 0 and __output_valid = 0.
- After reset deasserts, __output stays 0 for DEPTH-1 further edges until the first real tuple arrives.

## Configuration
- Macro: TUPLE_DELAY_VALID_EN.
- Defined: adds _i_valid and __output_valid, carried through a parallel DEPTH-stage 1-bit shift register that resets to 0 and has the same latency as the data. Data stages still shift every cycle regardless of valid.
- Undefined: neither port exists and there is no valid logic; the module has exactly the clock, reset, two field inputs and __output.

## Structure
- Shared package tuple_delay_pkg holds the default widths (W1 = 4, W2 = 4), the default depth (3), and a packed struct typedef tuple_t {field1, field2} that matches the bit layout above.
- Sub-module delay_stage: one parameterised register with synchronous active-high clear to 0. It is instantiated DEPTH times via generate, plus DEPTH times at width 1 for the valid path.
- The top level only packs the inputs and chains the stages.

## Test plan
- Reset hold: _i_rst = 1 for 2 cycles with arbitrary inputs -> __output = 0 on every cycle during reset and for 2 cycles after release.
- Single pulse: after reset, present input1 = 0, input2 = 1 for one cycle, then 0/0 -> __output = 8'h01 exactly 3 cycles after the sample edge, and 8'h00 on the following cycle.
- Field order: input1 = 4'hA, input2 = 4'h5 -> __output = 8'hA5 after 3 cycles, never 8'h5A.
- Streaming: feed 8'h00, 8'h11 … 8'hFF (as field pairs) on consecutive cycles -> identical sequence at the output, shifted by 3, with no gaps or duplicates.
- Mid-stream reset: 3 tuples in flight, assert _i_rst for 1 cycle -> __output = 0 from the next edge and none of the in-flight tuples ever appear.
- With TUPLE_DELAY_VALID_EN: set _i_valid = 1 only with 8'h3C -> __output_valid = 1 on exactly the cycle __output = 8'h3C, and 0 otherwise, including during reset.
